// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the parametrised SPI master
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Width of the chip-select index; never less than one bit
  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period counter producing sclk toggle strobes
module spi_sclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             edge_en,
  input  logic [DIV_W:0]   half,
  output logic             tick,
  output logic             lead_edge,
  output logic             trail_edge
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Count clk cycles within a half period; phase tracks leading vs trailing
  always_comb begin
    tick       = en && (({1'b0, cnt_q} + (DIV_W+1)'(1)) == half);
    cnt_d      = cnt_q + DIV_W'(1);
    if (!en || tick) begin
      cnt_d = '0;
    end
    phase_d    = phase_q;
    if (!edge_en) begin
      phase_d = 1'b0;
    end else if (tick) begin
      phase_d = ~phase_q;
    end
    lead_edge  = tick && edge_en && !phase_q;
    trail_edge = tick && edge_en && phase_q;
  end

  // Counter and phase registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - four-mode SPI master with runtime divider and CS bank
module spi_master_param #(
  parameter int DATA_W    = 8,
  parameter int NUM_CS    = 4,
  parameter int DIV_W     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [DATA_W-1:0]                    tx_data,
  input  logic                                 cpol,
  input  logic                                 cpha,
  input  logic [DIV_W-1:0]                     clk_div,
  input  logic [spi_pkg::cs_width(NUM_CS)-1:0] cs_sel,
  input  logic                                 miso,
  output logic                                 sclk,
  output logic                                 mosi,
  output logic [NUM_CS-1:0]                    cs_n,
  output logic                                 busy,
  output logic                                 done,
  output logic [DATA_W-1:0]                    rx_data
);

  import spi_pkg::*;

  localparam int            EW        = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EW-1:0]     edge_cnt_q, edge_cnt_d;

  logic              tick, lead_edge, trail_edge;
  logic [DIV_W:0]    half;
  logic [DATA_W-1:0] tx_shifted;

  // Bit currently at the head of the transmit word
  function automatic logic head(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  // Drop the head bit, moving the next one into place
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // Append a received bit so the word ends up in natural order
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  assign half       = {1'b0, div_q} + (DIV_W+1)'(1);
  assign tx_shifted = shift_out(tx_sh_q);

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (state_q != IDLE),
    .edge_en    (state_q == XFER),
    .half       (half),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  // Next-state and datapath: sequencing, shifting and sampling
  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;

    case (state_q)
      IDLE: begin
        sclk_d     = cpol;
        edge_cnt_d = '0;
        if (start) begin
          state_d = LEAD;
          busy_d  = 1'b1;
          cpha_d  = cpha;
          div_d   = clk_div;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          // An out-of-range cs_sel matches no bit, so every select stays high
          for (int i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = (int'(cs_sel) != i);
          end
          if (!cpha) begin
            mosi_d = head(tx_data);
          end
        end
      end

      LEAD: begin
        if (tick) begin
          state_d = XFER;
        end
      end

      XFER: begin
        if (lead_edge || trail_edge) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + EW'(1);
        end
        if (cpha_q ? trail_edge : lead_edge) begin
          rx_sh_d = shift_in(rx_sh_q, miso);
        end
        if (!cpha_q && trail_edge && (edge_cnt_q != LAST_EDGE)) begin
          tx_sh_d = tx_shifted;
          mosi_d  = head(tx_shifted);
        end
        if (cpha_q && lead_edge) begin
          mosi_d  = head(tx_sh_q);
          tx_sh_d = tx_shifted;
        end
        if (tick && (edge_cnt_q == LAST_EDGE)) begin
          state_d = TRAIL;
        end
      end

      TRAIL: begin
        if (tick) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cs_n_d    = '1;
          rx_data_d = rx_sh_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - directed bench for spi_master_param
module tb_spi_master_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit MSB-first instance with five selects (3-bit cs_sel)
  logic       start8, cpol8, cpha8, miso8, sclk8, mosi8, busy8, done8;
  logic [7:0] tx8, div8, rx8;
  logic [2:0] sel8;
  logic [4:0] cs_n8;
  logic       loop8;

  // 16-bit LSB-first instance with default select bank
  logic        start16, cpol16, cpha16, miso16, sclk16, mosi16, busy16, done16;
  logic [15:0] tx16, rx16;
  logic [7:0]  div16;
  logic [1:0]  sel16;
  logic [3:0]  cs_n16;

  spi_master_param #(.DATA_W(8), .NUM_CS(5), .DIV_W(8), .MSB_FIRST(1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .tx_data(tx8), .cpol(cpol8), .cpha(cpha8),
    .clk_div(div8), .cs_sel(sel8), .miso(miso8), .sclk(sclk8), .mosi(mosi8),
    .cs_n(cs_n8), .busy(busy8), .done(done8), .rx_data(rx8)
  );

  spi_master_param #(.DATA_W(16), .NUM_CS(4), .DIV_W(8), .MSB_FIRST(0)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .tx_data(tx16), .cpol(cpol16), .cpha(cpha16),
    .clk_div(div16), .cs_sel(sel16), .miso(miso16), .sclk(sclk16), .mosi(mosi16),
    .cs_n(cs_n16), .busy(busy16), .done(done16), .rx_data(rx16)
  );

  // Mode-matched slave on select 0, MSB first
  logic [7:0] s_tx, s_rx;
  logic       s_cpol, s_cpha;
  logic       s_miso = 1'b0;
  logic       s_prev_sel = 1'b0;
  logic       s_prev_sclk = 1'b0;
  int         s_bit = 0;

  assign miso8  = loop8 ? mosi8 : s_miso;
  assign miso16 = mosi16;

  always @(negedge clk) begin
    if (!cs_n8[0] && !s_prev_sel) begin
      s_bit <= 0;
      s_rx  <= 8'h00;
      if (!s_cpha) s_miso <= s_tx[7];
    end else if (!cs_n8[0] && (sclk8 != s_prev_sclk)) begin
      if (sclk8 != s_cpol) begin
        if (!s_cpha) begin
          s_rx <= {s_rx[6:0], mosi8};
        end else begin
          s_miso <= s_tx[7 - s_bit];
          s_bit  <= s_bit + 1;
        end
      end else begin
        if (!s_cpha) begin
          if (s_bit < 7) s_miso <= s_tx[6 - s_bit];
          s_bit <= s_bit + 1;
        end else begin
          s_rx <= {s_rx[6:0], mosi8};
        end
      end
    end
    s_prev_sel  <= !cs_n8[0];
    s_prev_sclk <= sclk8;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int w_busy, w_cslow, w_csany, w_done, w_edges;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [7:0] d, input logic p, input logic h,
                    input logic [7:0] div, input logic [2:0] sel);
    @(negedge clk);
    tx8 = d; cpol8 = p; cpha8 = h; div8 = div; sel8 = sel;
    s_cpol = p; s_cpha = h;
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Observe dut8 for up to budget cycles starting at the cycle after start acceptance
  task automatic watch(input int budget, input int mid_at, input logic chain,
                       input logic [7:0] chain_d);
    int   after;
    logic prev;
    w_busy = 0; w_cslow = 0; w_csany = 0; w_done = 0; w_edges = 0;
    after = -1;
    prev = sclk8;
    for (int i = 0; i < budget; i++) begin
      start8 = (i == mid_at);
      if (i == mid_at) begin
        tx8 = 8'hEE; cpha8 = ~cpha8; div8 = 8'h00;
      end
      if (busy8) w_busy++;
      if (!cs_n8[0]) w_cslow++;
      if (cs_n8 != 5'h1F) w_csany++;
      if (sclk8 != prev) w_edges++;
      prev = sclk8;
      if (done8) begin
        w_done++;
        if (chain) begin
          start8 = 1'b1;
          tx8 = chain_d;
          return;
        end
        if (after < 0) after = 0;
      end
      if (after >= 0) begin
        after++;
        if (after > 3) return;
      end
      @(negedge clk);
    end
  endtask

  logic [15:0] cap16;
  int          b16, csbad16;
  logic        prev16;

  initial begin
    reset = 1'b1;
    start8 = 0; tx8 = 0; cpol8 = 0; cpha8 = 0; div8 = 0; sel8 = 0; loop8 = 1;
    start16 = 0; tx16 = 0; cpol16 = 0; cpha16 = 0; div16 = 0; sel16 = 0;
    s_tx = 8'h00; s_cpol = 0; s_cpha = 0;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk8, 0);
    check("rst_mosi", mosi8, 0);
    check("rst_cs_n", cs_n8, 5'h1F);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_rx", rx8, 0);
    reset = 1'b0;

    // Mode 0 loopback, clk_div=0
    loop8 = 1;
    go(8'hA5, 0, 0, 8'd0, 3'd0);
    watch(200, -1, 0, 8'h00);
    check("m0_done", w_done, 1);
    check("m0_rx", rx8, 8'hA5);
    check("m0_busy", w_busy, 18);
    check("m0_cslow", w_cslow, 18);
    check("m0_edges", w_edges, 16);
    check("m0_idle", sclk8, 0);

    // Mode 3 with slave, clk_div=3
    loop8 = 0; s_tx = 8'hC3;
    go(8'h3C, 1, 1, 8'd3, 3'd0);
    watch(300, -1, 0, 8'h00);
    check("m3_rx", rx8, 8'hC3);
    check("m3_slave_rx", s_rx, 8'h3C);
    check("m3_busy", w_busy, 72);
    check("m3_idle", sclk8, 1);

    // Mode 1 with slave
    s_tx = 8'h5A;
    go(8'h81, 0, 1, 8'd1, 3'd0);
    watch(200, -1, 0, 8'h00);
    check("m1_rx", rx8, 8'h5A);
    check("m1_slave_rx", s_rx, 8'h81);
    check("m1_edges", w_edges, 16);

    // Mode 2 with slave
    s_tx = 8'h96;
    go(8'h81, 1, 0, 8'd0, 3'd0);
    watch(200, -1, 0, 8'h00);
    check("m2_rx", rx8, 8'h96);
    check("m2_slave_rx", s_rx, 8'h81);
    check("m2_idle", sclk8, 1);

    // start and config changes mid-transfer are ignored
    loop8 = 1;
    go(8'h11, 0, 0, 8'd1, 3'd0);
    watch(200, 10, 0, 8'h00);
    check("mid_done", w_done, 1);
    check("mid_rx", rx8, 8'h11);
    check("mid_busy", w_busy, 36);

    // start in the done cycle is accepted
    go(8'h6B, 0, 0, 8'd0, 3'd0);
    watch(200, -1, 1, 8'h5C);
    check("chain_first_done", w_done, 1);
    check("chain_first_rx", rx8, 8'h6B);
    @(negedge clk);
    start8 = 1'b0;
    check("chain_busy_next", busy8, 1);
    watch(200, -1, 0, 8'h00);
    check("chain_second_rx", rx8, 8'h5C);
    check("chain_second_busy", w_busy, 18);

    // Reset mid-transfer aborts with no done
    go(8'h77, 0, 0, 8'd1, 3'd0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs_n", cs_n8, 5'h1F);
    check("abort_sclk", sclk8, 0);
    check("abort_busy", busy8, 0);
    reset = 1'b0;
    watch(40, -1, 0, 8'h00);
    check("abort_no_done", w_done, 0);
    check("abort_rx", rx8, 8'h00);
    go(8'h3A, 0, 0, 8'd0, 3'd0);
    watch(200, -1, 0, 8'h00);
    check("after_abort_rx", rx8, 8'h3A);

    // Out-of-range select keeps every cs_n high
    go(8'h96, 0, 0, 8'd0, 3'd5);
    watch(200, -1, 0, 8'h00);
    check("oor_done", w_done, 1);
    check("oor_cs", w_csany, 0);
    check("oor_busy", w_busy, 18);

    // 16-bit LSB-first loopback on select 3
    @(negedge clk);
    tx16 = 16'h1234; sel16 = 2'd3; cpol16 = 0; cpha16 = 0; div16 = 0;
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cap16 = 16'h0000; b16 = 0; csbad16 = 0; prev16 = sclk16;
    for (int i = 0; i < 200; i++) begin
      if (busy16) b16++;
      if (busy16 && (cs_n16 != 4'b0111)) csbad16++;
      if (sclk16 && !prev16) cap16 = {mosi16, cap16[15:1]};
      prev16 = sclk16;
      if (done16) break;
      @(negedge clk);
    end
    check("w16_done", done16, 1);
    check("w16_mosi", cap16, 16'h1234);
    check("w16_rx", rx16, 16'h1234);
    check("w16_busy", b16, 34);
    check("w16_cs", csbad16, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
